d_pmp_seq: RTL

- Multi-cycle PMP checker for load/store accesses, placed between the LSU address-generation stage and the data memory request path.
- Scans the PMP entries one per cycle, lowest index first. The first matching entry's L/R/W/X bits go through one instance of d_pmp_rule (same ENABLE_SMEPMP), which yields the effective read/write permission.
- Trades latency for area: one comparator and one rule instance are shared across all entries.

---
 rtl/d_pmp_seq.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/d_pmp_seq.sv
// d_pmp_seq: multi-cycle PMP load/store checker sharing one comparator and one rule across entries.
// Optional one-entry result cache enabled by defining D_PMP_RESULT_CACHE_EN.
module d_pmp_rule #(
    parameter int ENABLE_SMEPMP = 1
) (
    input  logic m_mode_i,
    input  logic mml_i,
    input  logic l_i,
    input  logic r_i,
    input  logic w_i,
    input  logic x_i,
    output logic rd_o,
    output logic wr_o
);
    logic mml, owner, shared;
    always_comb begin
        mml    = (ENABLE_SMEPMP != 0) & mml_i;
        owner  = l_i ? m_mode_i : ~m_mode_i;
        shared = ~r_i & w_i;
        // MML: W-without-R encodes shared regions; L selects M-only vs S/U-only otherwise
        rd_o = !mml ? ((~l_i & m_mode_i) | r_i) :
               shared ? (l_i ? (x_i & m_mode_i) : 1'b1) :
               (l_i & r_i & w_i & x_i) ? 1'b1 : owner & r_i;
        wr_o = !mml ? ((~l_i & m_mode_i) | w_i) :
               shared ? (~l_i & (x_i | m_mode_i)) :
               (l_i & r_i & w_i & x_i) ? 1'b0 : owner & w_i;
    end
endmodule

module d_pmp_seq #(
    parameter int PMP_ENTRIES   = 8,
    parameter int ENABLE_SMEPMP = 1
) (
    input  logic                      cpu_clock_i,
    input  logic                      cpu_reset_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [31:0]               req_addr_i,
    input  logic                      req_write_i,
    input  logic                      req_mmode_i,
    input  logic                      mml_i,
    input  logic                      mmwp_i,
    input  logic [8*PMP_ENTRIES-1:0]  pmpcfg_i,
    input  logic [30*PMP_ENTRIES-1:0] pmpaddr_i,
    input  logic                      csr_write_i,
    input  logic                      flush_i,
    output logic                      resp_valid_o,
    output logic                      resp_allow_o,
    output logic                      resp_match_o,
    output logic [3:0]                resp_index_o
);
    typedef enum logic [1:0] {IDLE, CHECK, RESP} state_t;
    state_t      state_q;
    logic [3:0]  idx_q, index_q;
    logic [29:0] addr_q;
    logic        write_q, mmode_q, mml_q, mmwp_q, allow_q, match_q;
    logic [29:0] pa [16];
    logic [7:0]  pc [16];
    logic [29:0] upper, lower, napot_mask;
    logic [7:0]  cfg;
    logic        hit, last, rd, wr, allow_now, dflt, done, accept;
    logic        c_hit, c_allow, c_match;
    logic [3:0]  c_index;
    logic        unused_ok;

    // pad to 16 entries so a 4-bit index never selects outside the arrays
    for (genvar g = 0; g < 16; g++) begin : g_ent
        if (g < PMP_ENTRIES) begin : g_on
            assign pa[g] = pmpaddr_i[30*g +: 30];
            assign pc[g] = pmpcfg_i[8*g +: 8];
        end else begin : g_off
            assign pa[g] = '0;
            assign pc[g] = '0;
        end
    end

    always_comb begin
        cfg        = pc[idx_q];
        upper      = pa[idx_q];
        lower      = idx_q == 4'd0 ? '0 : pa[idx_q - 4'd1];
        napot_mask = ~(upper ^ (upper + 30'd1));
        hit        = cfg[4:3] == 2'd1 ? (lower <= addr_q && addr_q < upper) :
                     cfg[4:3] == 2'd2 ? addr_q == upper :
                     cfg[4:3] == 2'd3 ? ((addr_q ^ upper) & napot_mask) == '0 : 1'b0;
        last       = idx_q == 4'(PMP_ENTRIES - 1);
        dflt       = mmode_q & ~(mmwp_q & (ENABLE_SMEPMP != 0));
        allow_now  = hit ? (write_q ? wr : rd) : dflt;
        done       = state_q == CHECK && !flush_i && !csr_write_i && (hit || last);
        accept     = req_valid_i & req_ready_o & ~flush_i;
    end

    d_pmp_rule #(.ENABLE_SMEPMP(ENABLE_SMEPMP)) u_rule (
        .m_mode_i(mmode_q),
        .mml_i   (mml_q),
        .l_i     (cfg[7]),
        .r_i     (cfg[0]),
        .w_i     (cfg[1]),
        .x_i     (cfg[2]),
        .rd_o    (rd),
        .wr_o    (wr)
    );

`ifdef D_PMP_RESULT_CACHE_EN
    logic        c_valid_q, c_allow_q, c_match_q;
    logic [33:0] c_tag_q;
    logic [3:0]  c_index_q;
    assign c_hit   = c_valid_q & ~csr_write_i &
                     (c_tag_q == {req_addr_i[31:2], req_write_i, req_mmode_i, mml_i, mmwp_i});
    assign c_allow = c_allow_q;
    assign c_match = c_match_q;
    assign c_index = c_index_q;
    always_ff @(posedge cpu_clock_i) begin
        if (cpu_reset_i || csr_write_i) begin
            c_valid_q <= 1'b0;
        end else if (done) begin
            c_valid_q <= 1'b1;
            c_tag_q   <= {addr_q, write_q, mmode_q, mml_q, mmwp_q};
            c_allow_q <= allow_now;
            c_match_q <= hit;
            c_index_q <= hit ? idx_q : 4'd0;
        end
    end
`else
    assign c_hit   = 1'b0;
    assign c_allow = 1'b0;
    assign c_match = 1'b0;
    assign c_index = '0;
`endif

    always_ff @(posedge cpu_clock_i) begin
        if (cpu_reset_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            mmode_q <= 1'b0;
            mml_q   <= 1'b0;
            mmwp_q  <= 1'b0;
            allow_q <= 1'b0;
            match_q <= 1'b0;
            index_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    addr_q  <= req_addr_i[31:2];
                    write_q <= req_write_i;
                    mmode_q <= req_mmode_i;
                    mml_q   <= mml_i;
                    mmwp_q  <= mmwp_i;
                    idx_q   <= '0;
                    state_q <= c_hit ? RESP : CHECK;
                    if (c_hit) begin
                        allow_q <= c_allow;
                        match_q <= c_match;
                        index_q <= c_index;
                    end
                end
                CHECK: if (flush_i) begin
                    state_q <= IDLE;
                end else if (csr_write_i) begin
                    idx_q <= '0;
                end else if (done) begin
                    state_q <= RESP;
                    allow_q <= allow_now;
                    match_q <= hit;
                    index_q <= hit ? idx_q : 4'd0;
                end else begin
                    idx_q <= idx_q + 4'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o  = state_q == IDLE;
    assign resp_valid_o = state_q == RESP && !flush_i;
    assign resp_allow_o = allow_q;
    assign resp_match_o = match_q;
    assign resp_index_o = index_q;
    assign unused_ok    = ^{req_addr_i[1:0], cfg[6:5]};
endmodule
